weight_rd_arbiter: RTL

// - Shares the single weight/embedding RAM read port among NUM_REQ inference requesters.
//   - Req 0: embedding loader. Req 1: hidden-layer MAC. Req 2: logit stage.
// - Round-robin arbitration; exactly one outstanding RAM read at a time.
// - Sits between the inference sequencing logic and the RAM read controller.

---
 rtl/inference_pkg.sv | 29 ++
 rtl/weight_rd_arbiter_if.sv | 33 +++
 rtl/rr_priority_pick.sv | 40 ++++
 rtl/weight_rd_arbiter.sv | 106 ++++++++++
 4 files changed

// File: rtl/inference_pkg.sv
// Shared inference constants, RAM geometry and the weight-read arbiter state type.
package inference_pkg;

  localparam int VOCAB_SIZE     = 76;
  localparam int EMBEDDING_SIZE = 4;
  localparam int LINEAR_SIZE    = 8;

  localparam int RAM_ADDR_W  = 27;
  localparam int RAM_DATA_W  = 16;
  localparam int ARB_NUM_REQ = 3;

  localparam int REQ_EMB   = 0;
  localparam int REQ_HID   = 1;
  localparam int REQ_LOGIT = 2;

  localparam logic [RAM_DATA_W-1:0] TIMEOUT_DATA = 16'hDEAD;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DATA = 2'd2,
    RESPOND   = 2'd3
  } arb_state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/weight_rd_arbiter_if.sv
// Requester + RAM read-port bundle; slave is the arbiter side, master the requester/RAM side.
interface weight_rd_arbiter_if
  import inference_pkg::*;
#(
  parameter int NUM_REQ = ARB_NUM_REQ,
  parameter int ADDR_W  = RAM_ADDR_W,
  parameter int DATA_W  = RAM_DATA_W
);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        grant;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic                      rsp_err;
  logic                      ram_rd_req;
  logic [ADDR_W-1:0]         ram_rd_addr;
  logic                      ram_rd_ready;
  logic                      ram_rd_valid;
  logic [DATA_W-1:0]         ram_rd_data;
  logic [1:0]                dbg_state;

  modport slave (
    input  req, req_addr, ram_rd_ready, ram_rd_valid, ram_rd_data,
    output grant, rsp_valid, rsp_data, rsp_err, ram_rd_req, ram_rd_addr, dbg_state
  );

  modport master (
    output req, req_addr, ram_rd_ready, ram_rd_valid, ram_rd_data,
    input  grant, rsp_valid, rsp_data, rsp_err, ram_rd_req, ram_rd_addr, dbg_state
  );

endinterface

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first set req bit scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
module rr_priority_pick
  import inference_pkg::*;
#(
  parameter int NUM_REQ = ARB_NUM_REQ,
  localparam int IDX_W  = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic [IDX_W-1:0]   winner_idx,
  output logic               found
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] pos;

  // Scan from the farthest slot back to rr_ptr so the nearest hit is written last.
  always_comb begin
    winner     = '0;
    winner_idx = '0;
    found      = 1'b0;
    sum        = '0;
    pos        = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, rr_ptr} + (IDX_W + 1)'(k);
      if (sum >= (IDX_W + 1)'(NUM_REQ)) begin
        sum = sum - (IDX_W + 1)'(NUM_REQ);
      end
      pos = sum[IDX_W-1:0];
      if (req[pos]) begin
        winner      = '0;
        winner[pos] = 1'b1;
        winner_idx  = pos;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/weight_rd_arbiter.sv
// Round-robin arbiter for the single weight RAM read port, one read outstanding; req->rsp_valid 3 cycles min,
// ISSUE holds the command until ram_rd_ready. Optional WAIT_DATA watchdog under WEIGHT_ARB_TIMEOUT_EN.
module weight_rd_arbiter
  import inference_pkg::*;
#(
  parameter int NUM_REQ        = ARB_NUM_REQ,
  parameter int ADDR_W         = RAM_ADDR_W,
  parameter int DATA_W         = RAM_DATA_W,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input logic               clk,
  input logic               reset,
  weight_rd_arbiter_if.slave bus
);

  localparam int IDX_W = idx_w(NUM_REQ);

  arb_state_t         state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_found;

`ifdef WEIGHT_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;
`else
  assign bus.rsp_err = 1'b0;
`endif

  assign bus.dbg_state = state;

  rr_priority_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req        (bus.req),
    .rr_ptr     (rr_ptr),
    .winner     (pick_onehot),
    .winner_idx (pick_idx),
    .found      (pick_found)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      rr_ptr          <= '0;
      bus.grant       <= '0;
      bus.rsp_valid   <= '0;
      bus.rsp_data    <= '0;
      bus.ram_rd_req  <= 1'b0;
      bus.ram_rd_addr <= '0;
`ifdef WEIGHT_ARB_TIMEOUT_EN
      bus.rsp_err     <= 1'b0;
      wd_cnt          <= '0;
`endif
    end else begin
      bus.rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (pick_found) begin
            bus.grant       <= pick_onehot;
            bus.ram_rd_req  <= 1'b1;
            bus.ram_rd_addr <= bus.req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
            rr_ptr          <= (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
            state           <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.ram_rd_ready) begin
            bus.ram_rd_req <= 1'b0;
            state          <= WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          // grant is one-hot on the owner, so it doubles as the response strobe.
          if (bus.ram_rd_valid) begin
            bus.rsp_data  <= bus.ram_rd_data;
            bus.rsp_valid <= bus.grant;
            state         <= RESPOND;
`ifdef WEIGHT_ARB_TIMEOUT_EN
            wd_cnt        <= '0;
`endif
          end
`ifdef WEIGHT_ARB_TIMEOUT_EN
          else if (wd_cnt == WD_W'(TIMEOUT_CYCLES)) begin
            bus.rsp_data  <= TIMEOUT_DATA;
            bus.rsp_err   <= 1'b1;
            bus.rsp_valid <= bus.grant;
            wd_cnt        <= '0;
            state         <= RESPOND;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end
        RESPOND: begin
          bus.grant <= '0;
`ifdef WEIGHT_ARB_TIMEOUT_EN
          bus.rsp_err <= 1'b0;
`endif
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
